// File: rtl/plab5_mcore_mem_responder.sv
// rtl/plab5_mcore_mem_responder.sv - domain-tagged memory responder with request/response queues
module plab5_mcore_mem_responder #(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32,
    parameter int p_num_words    = 256
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        req_val,
    output logic                                        req_rdy,
    input  logic [3+p_opaque_nbits+p_addr_nbits+2-1:0]  req_control,
    input  logic [p_data_nbits-1:0]                     req_data,
    input  logic                                        req_domain,
    output logic                                        resp_val,
    input  logic                                        resp_rdy,
    output logic [3+p_opaque_nbits+2-1:0]               resp_control,
    output logic [p_data_nbits-1:0]                     resp_data,
    output logic                                        resp_domain
);
    localparam int CW  = 3 + p_opaque_nbits + p_addr_nbits + 2;
    localparam int RCW = 3 + p_opaque_nbits + 2;
    localparam int DW  = p_data_nbits;
    localparam int IW  = $clog2(p_num_words);
    localparam int NB  = p_data_nbits / 8;

    // request queue
    logic [CW-1:0]  rq_ctrl_q [2];
    logic [CW-1:0]  rq_ctrl_d [2];
    logic [DW-1:0]  rq_data_q [2];
    logic [DW-1:0]  rq_data_d [2];
    logic [1:0]     rq_dom_q, rq_dom_d;
    logic           rq_head_q, rq_head_d;
    logic [1:0]     rq_cnt_q, rq_cnt_d;
    logic           rq_tail;

    // access result stage; it counts against the response queue's two slots
    logic           s_val_q, s_val_d;
    logic [RCW-1:0] s_ctrl_q, s_ctrl_d;
    logic [DW-1:0]  s_data_q, s_data_d;
    logic           s_dom_q, s_dom_d;

    // response queue
    logic [RCW-1:0] pq_ctrl_q [2];
    logic [RCW-1:0] pq_ctrl_d [2];
    logic [DW-1:0]  pq_data_q [2];
    logic [DW-1:0]  pq_data_d [2];
    logic [1:0]     pq_dom_q, pq_dom_d;
    logic           pq_head_q, pq_head_d;
    logic [1:0]     pq_cnt_q, pq_cnt_d;
    logic           pq_tail;

    logic [DW-1:0]  mem_q [p_num_words];

    logic                      req_fire, resp_fire, acc_fire;
    logic [1:0]                resp_occ;
    logic [CW-1:0]             h_ctrl;
    logic [DW-1:0]             h_data;
    logic                      h_dom;
    logic [2:0]                h_type;
    logic [p_opaque_nbits-1:0] h_opq;
    logic [1:0]                h_len;
    logic [IW-1:0]             h_idx;
    logic                      h_blocked;
    logic [NB-1:0]             byte_en;
    logic [DW-1:0]             mem_word, rd_word, wr_word, acc_data;
    logic                      wr_en;
    logic                      unused_ctrl;

    assign req_rdy   = (rq_cnt_q != 2'd2);
    assign resp_val  = (pq_cnt_q != 2'd0);
    assign req_fire  = req_val && req_rdy;
    assign resp_fire = resp_val && resp_rdy;
    assign rq_tail   = rq_head_q ^ rq_cnt_q[0];
    assign pq_tail   = pq_head_q ^ pq_cnt_q[0];
    // slots of the response path still occupied after this edge's dequeue
    assign resp_occ  = pq_cnt_q + {1'b0, s_val_q} - {1'b0, resp_fire};
    assign acc_fire  = (rq_cnt_q != 2'd0) && (resp_occ < 2'd2);

    assign resp_control = resp_val ? pq_ctrl_q[pq_head_q] : '0;
    assign resp_data    = resp_val ? pq_data_q[pq_head_q] : '0;
    assign resp_domain  = resp_val ? pq_dom_q[pq_head_q]  : 1'b0;

    // decode the head request and compute its bank access and response data
    always_comb begin
        h_ctrl      = rq_ctrl_q[rq_head_q];
        h_data      = rq_data_q[rq_head_q];
        h_dom       = rq_dom_q[rq_head_q];
        unused_ctrl = ^h_ctrl;
        h_type      = h_ctrl[CW-1 -: 3];
        h_opq       = h_ctrl[p_addr_nbits+2 +: p_opaque_nbits];
        h_len       = h_ctrl[1:0];
        h_idx       = h_ctrl[4 +: IW];
        h_blocked   = h_idx[IW-1] && !h_dom;
        mem_word    = mem_q[h_idx];
        byte_en     = '0;
        rd_word     = '0;
        wr_word     = mem_word;
        for (int b = 0; b < NB; b++) begin
            byte_en[b] = (h_len == 2'd0) || (b < int'(h_len));
            if (byte_en[b]) begin
                rd_word[b*8 +: 8] = mem_word[b*8 +: 8];
                wr_word[b*8 +: 8] = h_data[b*8 +: 8];
            end
        end
        wr_en    = acc_fire && (h_type == 3'd1) && !h_blocked;
        acc_data = ((h_type == 3'd0) && !h_blocked) ? rd_word : '0;
    end

    // next-state for both queues and the access result stage
    always_comb begin
        rq_ctrl_d = rq_ctrl_q;
        rq_data_d = rq_data_q;
        rq_dom_d  = rq_dom_q;
        rq_head_d = rq_head_q ^ acc_fire;
        rq_cnt_d  = rq_cnt_q + {1'b0, req_fire} - {1'b0, acc_fire};
        if (req_fire) begin
            rq_ctrl_d[rq_tail] = req_control;
            rq_data_d[rq_tail] = req_data;
            rq_dom_d[rq_tail]  = req_domain;
        end

        s_val_d  = acc_fire;
        s_ctrl_d = s_ctrl_q;
        s_data_d = s_data_q;
        s_dom_d  = s_dom_q;
        if (acc_fire) begin
            s_ctrl_d = {h_type, h_opq, h_len};
            s_data_d = acc_data;
            s_dom_d  = h_dom;
        end

        pq_ctrl_d = pq_ctrl_q;
        pq_data_d = pq_data_q;
        pq_dom_d  = pq_dom_q;
        pq_head_d = pq_head_q ^ resp_fire;
        pq_cnt_d  = pq_cnt_q + {1'b0, s_val_q} - {1'b0, resp_fire};
        if (s_val_q) begin
            pq_ctrl_d[pq_tail] = s_ctrl_q;
            pq_data_d[pq_tail] = s_data_q;
            pq_dom_d[pq_tail]  = s_dom_q;
        end
    end

    // queue and stage registers; reset drops everything in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rq_ctrl_q <= '{default: '0};
            rq_data_q <= '{default: '0};
            rq_dom_q  <= '0;
            rq_head_q <= 1'b0;
            rq_cnt_q  <= 2'd0;
            s_val_q   <= 1'b0;
            s_ctrl_q  <= '0;
            s_data_q  <= '0;
            s_dom_q   <= 1'b0;
            pq_ctrl_q <= '{default: '0};
            pq_data_q <= '{default: '0};
            pq_dom_q  <= '0;
            pq_head_q <= 1'b0;
            pq_cnt_q  <= 2'd0;
        end else begin
            rq_ctrl_q <= rq_ctrl_d;
            rq_data_q <= rq_data_d;
            rq_dom_q  <= rq_dom_d;
            rq_head_q <= rq_head_d;
            rq_cnt_q  <= rq_cnt_d;
            s_val_q   <= s_val_d;
            s_ctrl_q  <= s_ctrl_d;
            s_data_q  <= s_data_d;
            s_dom_q   <= s_dom_d;
            pq_ctrl_q <= pq_ctrl_d;
            pq_data_q <= pq_data_d;
            pq_dom_q  <= pq_dom_d;
            pq_head_q <= pq_head_d;
            pq_cnt_q  <= pq_cnt_d;
        end
    end

    // bank write commits at the edge ending the access cycle; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[h_idx] <= wr_word;
        end
    end
endmodule

// File: tb/tb_plab5_mcore_mem_responder.sv
// tb/tb_plab5_mcore_mem_responder.sv - randomized and directed bench with behavioural memory model
module tb_plab5_mcore_mem_responder;
    logic        clk;
    logic        reset;
    logic        req_val;
    logic        req_rdy;
    logic [44:0] req_control;
    logic [31:0] req_data;
    logic        req_domain;
    logic        resp_val;
    logic        resp_rdy;
    logic [12:0] resp_control;
    logic [31:0] resp_data;
    logic        resp_domain;

    plab5_mcore_mem_responder dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_control(req_control),
        .req_data(req_data), .req_domain(req_domain),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_control(resp_control),
        .resp_data(resp_data), .resp_domain(resp_domain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mdl_mem [256];
    logic [45:0] exp_q [$];
    logic        rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // reference: word index is (addr/4) mod 256, upper half needs domain 1
    task automatic model_accept(input logic [2:0] t, input logic [7:0] opq, input logic [31:0] addr,
                                input logic [1:0] len, input logic [31:0] data, input logic dom);
        int          idx;
        int          nb;
        logic [31:0] mask;
        logic [31:0] rd;
        logic        blocked;
        idx     = int'((addr >> 2) % 32'd256);
        blocked = (idx >= 128) && (dom == 1'b0);
        nb      = (len == 2'd0) ? 4 : int'(len);
        mask    = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        rd      = 32'h0;
        if (t == 3'd0 && !blocked) rd = mdl_mem[idx] & mask;
        if (t == 3'd1 && !blocked) mdl_mem[idx] = (mdl_mem[idx] & ~mask) | (data & mask);
        exp_q.push_back({t, opq, len, rd, dom});
    endtask

    task automatic send(input logic [2:0] t, input logic [7:0] opq, input logic [31:0] addr,
                        input logic [1:0] len, input logic [31:0] data, input logic dom);
        int n = 0;
        req_val     = 1'b1;
        req_control = {t, opq, addr, len};
        req_data    = data;
        req_domain  = dom;
        while (!req_rdy && n < 200) begin
            @(negedge clk);
            n++;
            if (rand_rdy) resp_rdy = ($urandom_range(0, 3) != 0);
        end
        if (!req_rdy) begin
            chk("req_accept", 64'(req_rdy), 64'd1);
            req_val = 1'b0;
            return;
        end
        model_accept(t, opq, addr, len, data, dom);
        @(negedge clk);
        if (rand_rdy) resp_rdy = ($urandom_range(0, 3) != 0);
        req_val = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input logic [2:0] et, input logic [31:0] ed, input logic edom);
        int n = 0;
        while (!resp_val && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_val"}, 64'(resp_val), 64'd1);
        chk({tag, "_type"}, 64'(resp_control[12:10]), 64'(et));
        chk({tag, "_data"}, 64'(resp_data), 64'(ed));
        chk({tag, "_dom"}, 64'(resp_domain), 64'(edom));
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic lat_check(input string tag, input logic [7:0] opq);
        send(3'd0, opq, 32'h10, 2'd0, 32'h0, 1'b0);
        chk({tag, "_t0"}, 64'(resp_val), 64'd0);
        @(negedge clk);
        chk({tag, "_t1"}, 64'(resp_val), 64'd0);
        @(negedge clk);
        chk({tag, "_t2"}, 64'(resp_val), 64'd1);
        chk({tag, "_opq"}, 64'(resp_control[9:2]), 64'(opq));
        chk({tag, "_data"}, 64'(resp_data), 64'hDEADBEEF);
        @(negedge clk);
    endtask

    // response monitor: order/content against the model, plus output hold under backpressure
    logic        hold_pend = 1'b0;
    logic [46:0] held;
    logic [45:0] mon_e;
    always begin
        @(negedge clk);
        #1;
        if (!reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) chk("resp_hold", 64'({resp_val, resp_control, resp_data, resp_domain}), 64'(held));
            if (resp_val && resp_rdy) begin
                chk("resp_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("resp_control", 64'(resp_control), 64'(mon_e[45:33]));
                    chk("resp_data", 64'(resp_data), 64'(mon_e[32:1]));
                    chk("resp_domain", 64'(resp_domain), 64'(mon_e[0]));
                end
            end
            hold_pend = resp_val && !resp_rdy;
            held      = {resp_val, resp_control, resp_data, resp_domain};
        end
    end

    initial begin
        int         acc;
        int         r;
        logic [2:0] t;
        logic [31:0] addr;
        reset = 1'b0; req_val = 1'b0; req_control = '0; req_data = '0; req_domain = 1'b0; resp_rdy = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_resp_val", 64'(resp_val), 64'd0);
        chk("rst_resp_control", 64'(resp_control), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_resp_domain", 64'(resp_domain), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_req_rdy", 64'(req_rdy), 64'd1);
        chk("rel_resp_val", 64'(resp_val), 64'd0);

        for (int i = 0; i < 256; i++) send(3'd1, 8'(i), 32'(i * 4), 2'd0, $urandom, 1'b1);
        drain();

        send(3'd1, 8'h01, 32'h10, 2'd0, 32'hDEADBEEF, 1'b0);
        wait_resp("wr10", 3'd1, 32'h0, 1'b0);
        lat_check("lat", 8'h5A);

        send(3'd1, 8'h02, 32'h20, 2'd0, 32'hFFFFFFFF, 1'b0);
        wait_resp("pre20", 3'd1, 32'h0, 1'b0);
        send(3'd1, 8'h03, 32'h20, 2'd1, 32'h000000AB, 1'b0);
        wait_resp("byte_wr", 3'd1, 32'h0, 1'b0);
        send(3'd0, 8'h04, 32'h20, 2'd0, 32'h0, 1'b0);
        wait_resp("byte_rd4", 3'd0, 32'hFFFFFFAB, 1'b0);
        send(3'd0, 8'h05, 32'h20, 2'd2, 32'h0, 1'b0);
        wait_resp("byte_rd2", 3'd0, 32'h0000FFAB, 1'b0);

        send(3'd1, 8'h06, 32'h200, 2'd0, 32'h12345678, 1'b1);
        wait_resp("sec_wr_h", 3'd1, 32'h0, 1'b1);
        send(3'd1, 8'h07, 32'h200, 2'd0, 32'h0, 1'b0);
        wait_resp("sec_wr_l", 3'd1, 32'h0, 1'b0);
        send(3'd0, 8'h08, 32'h200, 2'd0, 32'h0, 1'b0);
        wait_resp("sec_rd_l", 3'd0, 32'h0, 1'b0);
        send(3'd0, 8'h09, 32'h200, 2'd0, 32'h0, 1'b1);
        wait_resp("sec_rd_h", 3'd0, 32'h12345678, 1'b1);

        send(3'd0, 8'h0A, 32'h410, 2'd0, 32'h0, 1'b0);
        wait_resp("wrap", 3'd0, 32'hDEADBEEF, 1'b0);
        send(3'd3, 8'h0B, 32'h10, 2'd0, 32'h55, 1'b0);
        wait_resp("type3", 3'd3, 32'h0, 1'b0);
        send(3'd0, 8'h0C, 32'h10, 2'd0, 32'h0, 1'b0);
        wait_resp("type3_nochg", 3'd0, 32'hDEADBEEF, 1'b0);

        send(3'd1, 8'h0D, 32'h30, 2'd0, 32'hCAFEF00D, 1'b0);
        send(3'd0, 8'h0E, 32'h30, 2'd0, 32'h0, 1'b0);
        wait_resp("raw_wr", 3'd1, 32'h0, 1'b0);
        wait_resp("raw_rd", 3'd0, 32'hCAFEF00D, 1'b0);
        drain();

        resp_rdy = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            req_val = 1'b1; req_control = {3'd0, 8'(acc), 32'h10, 2'd0}; req_data = '0; req_domain = 1'b0;
            if (req_rdy) begin
                model_accept(3'd0, 8'(acc), 32'h10, 2'd0, 32'h0, 1'b0);
                acc++;
            end
            @(negedge clk);
        end
        chk("bp_accepted", 64'(acc), 64'd4);
        chk("bp_req_rdy", 64'(req_rdy), 64'd0);
        resp_rdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk("bp_stream_val", 64'(resp_val), 64'd1);
            chk("bp_stream_opq", 64'(resp_control[9:2]), 64'(c));
            req_val = (acc < 6); req_control = {3'd0, 8'(acc), 32'h10, 2'd0};
            if (req_val && req_rdy) begin
                model_accept(3'd0, 8'(acc), 32'h10, 2'd0, 32'h0, 1'b0);
                acc++;
            end
            @(negedge clk);
        end
        req_val = 1'b0;
        while (acc < 6) begin
            send(3'd0, 8'(acc), 32'h10, 2'd0, 32'h0, 1'b0);
            acc++;
        end
        drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r    = $urandom_range(0, 9);
            t    = (r < 4) ? 3'd0 : (r < 8) ? 3'd1 : 3'(r - 5);
            addr = ($urandom & 32'hFFFF_F000) | (($urandom_range(0, 1) != 0) ? 32'h200 : 32'h0)
                 | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            send(t, 8'(i), addr, 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                resp_rdy = ($urandom_range(0, 3) != 0);
            end
        end
        rand_rdy = 1'b0;
        resp_rdy = 1'b1;
        drain();

        resp_rdy = 1'b0;
        send(3'd0, 8'hA0, 32'h10, 2'd0, 32'h0, 1'b0);
        send(3'd0, 8'hA1, 32'h20, 2'd0, 32'h0, 1'b0);
        send(3'd0, 8'hA2, 32'h30, 2'd0, 32'h0, 1'b0);
        chk("mid_pre_val", 64'(resp_val), 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_async_val", 64'(resp_val), 64'd0);
        chk("mid_async_data", 64'(resp_data), 64'd0);
        chk("mid_async_ctrl", 64'(resp_control), 64'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rel_rdy", 64'(req_rdy), 64'd1);
        chk("mid_rel_val", 64'(resp_val), 64'd0);
        resp_rdy = 1'b1;
        @(negedge clk);
        chk("mid_no_stale", 64'(resp_val), 64'd0);
        lat_check("mid_lat", 8'hB0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
